kernel_onchip_memory_arbiter: RTL and testbench

Two-master round-robin arbiter sharing the single-port 32-bit on-chip RAM (20480 words, 15-bit word address, byte enables) between the Nios II instruction master (m0) and data master (m1). It sits directly in front of the RAM's slave port. It issues at most one command per cycle, stalls the losing master with waitrequest, and returns read data with per-master readdatavalid. It tracks in-flight reads through a tag pipeline matched to the RAM read latency.

---
 rtl/kernel_onchip_memory_arbiter_if.sv | 26 ++
 rtl/kernel_onchip_memory_arbiter.sv | 89 ++++++++
 tb/tb_kernel_onchip_memory_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/kernel_onchip_memory_arbiter_if.sv
// Avalon-MM master port bundle for one arbiter client.
// Master drives the command, slave returns wait/read data.
interface kernel_onchip_memory_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/kernel_onchip_memory_arbiter.sv
// Round-robin m0/m1 arbiter in front of the on-chip RAM.
// Read responses are steered by a latency-matched tag pipe.
module kernel_onchip_memory_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  kernel_onchip_memory_arbiter_if.slave m0,
  kernel_onchip_memory_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [BE_W-1:0]      mem_byteenable,
  output logic                 mem_chipselect,
  output logic                 mem_write,
  output logic [DATA_W-1:0]    mem_writedata,
  output logic                 mem_clken,
  input  logic [DATA_W-1:0]    mem_readdata
);

  logic req0;
  logic req1;
  logic gnt0;
  logic gnt1;
  logic rd_acc;
  logic last_grant;
  logic out_vld;
  logic out_tid;

  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] tid_q;

  // Grant: lone requester wins, else the one not served last.
  always_comb begin
    req0   = m0.read | m0.write;
    req1   = m1.read | m1.write;
    gnt0   = reset_n & req0 & (~req1 | last_grant);
    gnt1   = reset_n & req1 & (~req0 | ~last_grant);
    rd_acc = (gnt0 & m0.read & ~m0.write)
           | (gnt1 & m1.read & ~m1.write);
  end

  // Steer the winner's command onto the RAM port.
  always_comb begin
    mem_chipselect = gnt0 | gnt1;
    mem_write      = (gnt0 & m0.write) | (gnt1 & m1.write);
    mem_address    = m0.address;
    mem_writedata  = m0.writedata;
    mem_byteenable = m0.write ? m0.byteenable : '1;
    if (gnt1) begin
      mem_address    = m1.address;
      mem_writedata  = m1.writedata;
      mem_byteenable = m1.write ? m1.byteenable : '1;
    end
  end

  assign mem_clken = 1'b1;

  // Per-master handshake and response outputs.
  always_comb begin
    out_vld          = reset_n & vld_q[READ_LATENCY-1];
    out_tid          = tid_q[READ_LATENCY-1];
    m0.waitrequest   = ~gnt0;
    m1.waitrequest   = ~gnt1;
    m0.readdatavalid = out_vld & ~out_tid;
    m1.readdatavalid = out_vld & out_tid;
    m0.readdata      = mem_readdata;
    m1.readdata      = mem_readdata;
  end

  // Arbitration history and read-valid pipe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      vld_q      <= '0;
    end else begin
      if (gnt0 | gnt1)
        last_grant <= gnt1;
      vld_q <= READ_LATENCY'({vld_q, rd_acc});
    end
  end

  // Issuer id travels alongside each valid bit.
  always_ff @(posedge clk) begin
    tid_q <= READ_LATENCY'({tid_q, gnt1});
  end

endmodule

// File: tb/tb_kernel_onchip_memory_arbiter.sv
// Bench for kernel_onchip_memory_arbiter.
// Drives latency-1 and latency-2 instances in lockstep.
module tb_kernel_onchip_memory_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t qa[$];
  exp_t qb[$];

  logic        c0_rd, c0_wr, c1_rd, c1_wr;
  logic [14:0] c0_addr, c1_addr;
  logic [3:0]  c0_be, c1_be;
  logic [31:0] c0_wd, c1_wd;

  logic [14:0] ma_addr, mb_addr;
  logic [3:0]  ma_be, mb_be;
  logic        ma_cs, mb_cs, ma_we, mb_we, ma_ck, mb_ck;
  logic [31:0] ma_wd, mb_wd, ma_rd, mb_rd;
  logic [31:0] qa1, qb1, qb2;

  logic [31:0] ram_a [0:32767];
  logic [31:0] ram_b [0:32767];

  kernel_onchip_memory_arbiter_if a0 ();
  kernel_onchip_memory_arbiter_if a1 ();
  kernel_onchip_memory_arbiter_if b0 ();
  kernel_onchip_memory_arbiter_if b1 ();

  assign a0.address = c0_addr;  assign b0.address = c0_addr;
  assign a0.byteenable = c0_be; assign b0.byteenable = c0_be;
  assign a0.read = c0_rd;       assign b0.read = c0_rd;
  assign a0.write = c0_wr;      assign b0.write = c0_wr;
  assign a0.writedata = c0_wd;  assign b0.writedata = c0_wd;
  assign a1.address = c1_addr;  assign b1.address = c1_addr;
  assign a1.byteenable = c1_be; assign b1.byteenable = c1_be;
  assign a1.read = c1_rd;       assign b1.read = c1_rd;
  assign a1.write = c1_wr;      assign b1.write = c1_wr;
  assign a1.writedata = c1_wd;  assign b1.writedata = c1_wd;

  kernel_onchip_memory_arbiter #(.READ_LATENCY(1)) dut_a (
    .clk(clk), .reset_n(rst_n), .m0(a0), .m1(a1),
    .mem_address(ma_addr), .mem_byteenable(ma_be),
    .mem_chipselect(ma_cs), .mem_write(ma_we),
    .mem_writedata(ma_wd), .mem_clken(ma_ck),
    .mem_readdata(ma_rd)
  );

  kernel_onchip_memory_arbiter #(.READ_LATENCY(2)) dut_b (
    .clk(clk), .reset_n(rst_n), .m0(b0), .m1(b1),
    .mem_address(mb_addr), .mem_byteenable(mb_be),
    .mem_chipselect(mb_cs), .mem_write(mb_we),
    .mem_writedata(mb_wd), .mem_clken(mb_ck),
    .mem_readdata(mb_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: registered address, q after 1 or 2 edges.
  always @(posedge clk) begin
    if (ma_ck && ma_cs && ma_we)
      for (int i = 0; i < 4; i++)
        if (ma_be[i]) ram_a[ma_addr][8*i +: 8] <= ma_wd[8*i +: 8];
    if (ma_ck && ma_cs && !ma_we) qa1 <= ram_a[ma_addr];
  end

  always @(posedge clk) begin
    if (mb_ck && mb_cs && mb_we)
      for (int i = 0; i < 4; i++)
        if (mb_be[i]) ram_b[mb_addr][8*i +: 8] <= mb_wd[8*i +: 8];
    if (mb_ck && mb_cs && !mb_we) qb1 <= ram_b[mb_addr];
    qb2 <= qb1;
  end

  assign ma_rd = qa1;
  assign mb_rd = qb2;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic set0(input logic r, input logic w, input logic [14:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    c0_rd = r; c0_wr = w; c0_addr = a; c0_be = be; c0_wd = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [14:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    c1_rd = r; c1_wr = w; c1_addr = a; c1_be = be; c1_wd = d;
  endtask

  // One cycle: check handshake/command, optionally expect a read.
  task automatic step(input logic ew0, input logic ew1, input logic ecs,
                      input logic ewr, input logic [3:0] ebe,
                      input logic pu, input logic pid,
                      input logic [31:0] pd);
    @(negedge clk);
    chk("L1 m0_wait", a0.waitrequest, ew0);
    chk("L1 m1_wait", a1.waitrequest, ew1);
    chk("L1 mem_cs", ma_cs, ecs);
    chk("L1 mem_we", ma_we, ewr);
    chk("L2 m0_wait", b0.waitrequest, ew0);
    chk("L2 m1_wait", b1.waitrequest, ew1);
    chk("L2 mem_cs", mb_cs, ecs);
    chk("L2 mem_we", mb_we, ewr);
    if (ecs) begin
      chk("L1 mem_be", ma_be, ebe);
      chk("L2 mem_be", mb_be, ebe);
    end
    if (pu) begin
      qa.push_back('{id: pid, data: pd, cyc: cyc});
      qb.push_back('{id: pid, data: pd, cyc: cyc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    set0(0, 0, 0, 4'hF, 0);
    set1(0, 0, 0, 4'hF, 0);
    repeat (n) step(1, 1, 0, 0, 4'hF, 0, 0, 0);
  endtask

  // Response monitor, latency 1.
  always @(negedge clk) begin
    exp_t e;
    if (a0.readdatavalid || a1.readdatavalid) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL L1 stray_valid got m0=%b m1=%b exp none",
                 a0.readdatavalid, a1.readdatavalid);
      end else begin
        e = qa.pop_front();
        chk("L1 rd_valid_m0", a0.readdatavalid, !e.id);
        chk("L1 rd_valid_m1", a1.readdatavalid, e.id);
        chk("L1 rd_data", e.id ? a1.readdata : a0.readdata, e.data);
        chk("L1 rd_cycle", cyc, e.cyc + 1);
      end
    end
  end

  // Response monitor, latency 2.
  always @(negedge clk) begin
    exp_t e;
    if (b0.readdatavalid || b1.readdatavalid) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL L2 stray_valid got m0=%b m1=%b exp none",
                 b0.readdatavalid, b1.readdatavalid);
      end else begin
        e = qb.pop_front();
        chk("L2 rd_valid_m0", b0.readdatavalid, !e.id);
        chk("L2 rd_valid_m1", b1.readdatavalid, e.id);
        chk("L2 rd_data", e.id ? b1.readdata : b0.readdata, e.data);
        chk("L2 rd_cycle", cyc, e.cyc + 2);
      end
    end
  end

  initial begin
    set0(1, 0, 15'h100, 4'hF, 0);
    set1(1, 0, 15'h200, 4'hF, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    // Reset held with both masters requesting.
    repeat (3) step(1, 1, 0, 0, 4'hF, 0, 0, 0);
    rst_n = 1'b1;
    // Contending writes: m0 first after reset, then m1.
    set0(0, 1, 15'h100, 4'hF, 32'hA0A0_0100);
    set1(0, 1, 15'h200, 4'hF, 32'hB1B1_0200);
    step(0, 1, 1, 1, 4'hF, 0, 0, 0);
    set0(0, 0, 0, 4'hF, 0);
    step(1, 0, 1, 1, 4'hF, 0, 0, 0);
    // Continuous contending reads alternate m0, m1.
    set0(1, 0, 15'h100, 4'hF, 0);
    set1(1, 0, 15'h200, 4'hF, 0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        step(0, 1, 1, 0, 4'hF, 1, 0, 32'hA0A0_0100);
      else
        step(1, 0, 1, 0, 4'hF, 1, 1, 32'hB1B1_0200);
    end
    idle_steps(3);
    // Single master write then read.
    set1(0, 1, 15'h010, 4'hF, 32'hDEAD_BEEF);
    step(1, 0, 1, 1, 4'hF, 0, 0, 0);
    set1(1, 0, 15'h010, 4'h0, 0);
    step(1, 0, 1, 0, 4'hF, 1, 1, 32'hDEAD_BEEF);
    idle_steps(3);
    // Byte-lane merge.
    set0(0, 1, 15'h005, 4'hF, 32'h1122_3344);
    step(0, 1, 1, 1, 4'hF, 0, 0, 0);
    set0(0, 1, 15'h005, 4'b0101, 32'hAABB_CCDD);
    step(0, 1, 1, 1, 4'b0101, 0, 0, 0);
    set0(1, 0, 15'h005, 4'h0, 0);
    step(0, 1, 1, 0, 4'hF, 1, 0, 32'h11BB_33DD);
    idle_steps(3);
    // Read and write together act as a write.
    set0(1, 1, 15'h007, 4'hF, 32'h5A5A_5A5A);
    step(0, 1, 1, 1, 4'hF, 0, 0, 0);
    set0(1, 0, 15'h007, 4'hF, 0);
    step(0, 1, 1, 0, 4'hF, 1, 0, 32'h5A5A_5A5A);
    idle_steps(3);
    // Read accepted, then reset: response must vanish.
    set0(1, 0, 15'h010, 4'hF, 0);
    step(0, 1, 1, 0, 4'hF, 0, 0, 0);
    set0(0, 0, 0, 4'hF, 0);
    rst_n = 1'b0;
    step(1, 1, 0, 0, 4'hF, 0, 0, 0);
    rst_n = 1'b1;
    // After reset m0 must win contention again.
    set0(1, 0, 15'h200, 4'hF, 0);
    set1(1, 0, 15'h100, 4'hF, 0);
    step(0, 1, 1, 0, 4'hF, 1, 0, 32'hB1B1_0200);
    set0(0, 0, 0, 4'hF, 0);
    step(1, 0, 1, 0, 4'hF, 1, 1, 32'hA0A0_0100);
    idle_steps(4);
    chk("L1 pending_reads", qa.size(), 0);
    chk("L2 pending_reads", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
